// File: rtl/anc_pkg.sv
// Shared Q15 constants and saturation helpers for the ANC noise subtractor.
// Optional build macro: ANC_ROUND_EN (round half up before the Q15 shift).
package anc_pkg;

  // Default noise gain, about 0.797 in Q15
  localparam int COEF_DEFAULT = 26123;
  // Q15 scaling shift and the half-LSB used for rounding
  localparam int Q15_SHIFT    = 15;
  localparam int Q15_ROUND    = 1 << (Q15_SHIFT - 1);

  // Largest value representable in a w-bit signed word
  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit signed word
  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/anc_delay_line.sv
// Circular noise buffer: one write port, one delayed read port, registered read.
// Slots not yet written since reset read as zero via the fill counter.
module anc_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic signed [DATA_W-1:0]   wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_delay,
  output logic signed [DATA_W-1:0]   rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW:0]              fill;
  logic [AW-1:0]            rd_addr;
  logic                     rd_hit;

  // Delay 0 bypasses the array; otherwise the slot must have been written
  assign rd_addr = wr_ptr - rd_delay;
  assign rd_hit  = ({1'b0, rd_delay} <= fill);

  // Storage array, no reset needed since fill masks stale contents
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer, fill counter and registered read, all advancing per write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      fill    <= '0;
      rd_data <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != FULL) begin
        fill <= fill + 1'b1;
      end
      if (rd_delay == '0) begin
        rd_data <= wr_data;
      end else if (rd_hit) begin
        rd_data <= mem[rd_addr];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: rtl/anc_noise_subtract.sv
// Adaptive-free noise canceller: out = sat(primary - (delayed_noise * COEF) >>> 15).
// Three-stage pipeline (read, multiply, subtract/saturate) that stalls as a unit.
// Optional build macro: ANC_ROUND_EN adds a half-LSB before the Q15 shift.
module anc_noise_subtract import anc_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int COEF   = COEF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   primary,
  input  logic signed [DATA_W-1:0]   noise,
  input  logic [$clog2(DEPTH)-1:0]   delay_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       sat_flag
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW-1:0] COEF_S = PW'(COEF);
  localparam logic signed [PW:0]   HI     = (PW + 1)'(sat_hi(DATA_W));
  localparam logic signed [PW:0]   LO     = (PW + 1)'(sat_lo(DATA_W));

  logic advance;
  logic accept;

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_primary;
  logic signed [DATA_W-1:0] s1_delayed;

  logic                     s2_valid;
  logic signed [DATA_W-1:0] s2_primary;
  logic signed [PW-1:0]     s2_product;

  logic signed [PW:0]       sum;
  logic signed [PW:0]       diff;
  logic                     ovf_hi;
  logic                     ovf_lo;
  logic signed [DATA_W-1:0] clipped;

  // Every stage moves together whenever the output slot is free
  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;
  assign accept   = in_valid && in_ready && !rst;

  anc_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_delay_line (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_data  (noise),
    .rd_delay (delay_sel),
    .rd_data  (s1_delayed)
  );

  // S1: capture primary alongside the registered delay-line read
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid   <= accept;
      s1_primary <= primary;
    end
  end

  // S2: scale the delayed noise by the Q15 gain
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid   <= s1_valid;
      s2_primary <= s1_primary;
      s2_product <= PW'(s1_delayed) * COEF_S;
    end
  end

  // S3 datapath: Q15 shift, subtract, clip to the output range
  always_comb begin
`ifdef ANC_ROUND_EN
    sum = (PW + 1)'(s2_product) + (PW + 1)'(Q15_ROUND);
`else
    sum = (PW + 1)'(s2_product);
`endif
    diff   = (PW + 1)'(s2_primary) - (sum >>> Q15_SHIFT);
    ovf_hi = (diff > HI);
    ovf_lo = (diff < LO);
    if (ovf_hi) begin
      clipped = HI[DATA_W-1:0];
    end else if (ovf_lo) begin
      clipped = LO[DATA_W-1:0];
    end else begin
      clipped = diff[DATA_W-1:0];
    end
  end

  // Output register, held while downstream back-pressures
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= clipped;
        sat_flag <= ovf_hi || ovf_lo;
      end else begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_anc_noise_subtract.sv
// Scoreboard bench for anc_noise_subtract: the driver pushes expected outputs on
// acceptance, a monitor pops and compares on every output handshake.
module tb_anc_noise_subtract;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] primary = '0;
  logic signed [15:0] noise = '0;
  logic [4:0]         delay_sel = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic               sat_flag;

  anc_noise_subtract #(
    .DATA_W (16),
    .DEPTH  (32),
    .COEF   (26123)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .primary   (primary),
    .noise     (noise),
    .delay_sel (delay_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint data;
    bit     sat;
    bit     lat;
    int     acc;
    string  name;
  } exp_t;

  exp_t   sb[$];
  longint hist[$];
  int     total = 0;
  int     bad = 0;

`ifdef ANC_ROUND_EN
  localparam longint EXP_T2 = -80;
`else
  localparam longint EXP_T2 = -79;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint scale(input longint n);
    longint pr;
    pr = n * 26123;
`ifdef ANC_ROUND_EN
    pr = pr + 16384;
`endif
    return pr >>> 15;
  endfunction

  // Expected output for a sample given the noise history seen so far
  function automatic void model(input longint p, input longint n, input int d,
                                output longint ed, output bit es);
    longint dn;
    if (d == 0) dn = n;
    else if (d <= hist.size()) dn = hist[d-1];
    else dn = 0;
    ed = p - scale(dn);
    es = 1'b0;
    if (ed > 32767) begin
      ed = 32767;
      es = 1'b1;
    end else if (ed < -32768) begin
      ed = -32768;
      es = 1'b1;
    end
  endfunction

  // Present one sample starting at a negedge; returns on the negedge after acceptance
  task automatic send(input longint p, input longint n, input int d, input longint ed,
                      input bit es, input bit lat, input string name);
    exp_t e;
    primary   = 16'(p);
    noise     = 16'(n);
    delay_sel = 5'(d);
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        e.data = ed;
        e.sat  = es;
        e.lat  = lat;
        e.acc  = cyc;
        e.name = name;
        sb.push_back(e);
        hist.push_front(n);
        if (hist.size() > 32) void'(hist.pop_back());
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL %s_accept_timeout: got in_ready=0 expected 1", name);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input longint p, input longint n, input int d, input bit lat,
                        input string name);
    longint ed;
    bit     es;
    model(p, n, d, ed, es);
    send(p, n, d, ed, es, lat, name);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    hist.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(negedge clk);
      #3;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d outputs pending expected 0", name, sb.size());
    end
  endtask

  // Monitor: compare every handshaken output against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0d expected none", out_data);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_data"}, out_data, e.data);
          chk({e.name, "_sat"}, sat_flag, e.sat);
          if (e.lat) chk({e.name, "_latency"}, cyc - e.acc, 3);
        end
      end
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_sat_flag", sat_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);

    // Current-sample noise, 1000*26123>>15 = 797
    send(1000, 1000, 0, 203, 0, 1, "basic");
    drain("basic");

    // Delay of 3 with unwritten history reading zero
    apply_reset();
    send(0, 100, 3, 0, 0, 1, "delay3_a");
    send(0, 200, 3, 0, 0, 1, "delay3_b");
    send(0, 300, 3, 0, 0, 1, "delay3_c");
    send(0, 400, 3, EXP_T2, 0, 1, "delay3_d");
    drain("delay3");

    // Positive saturation, then a clean zero sample
    apply_reset();
    send(32767, -32768, 0, 32767, 1, 1, "sat_hi");
    send(0, 0, 0, 0, 0, 1, "sat_clear");
    send(-32768, 32767, 0, -32768, 1, 1, "sat_lo");
    drain("sat");

    // Back-pressure: hold output for 5 cycles with a sample waiting
    apply_reset();
    for (int k = 0; k < 3; k++) send_m(1000 * k, 3000 - 2000 * k, 1, 0, "stall");
    out_ready = 1'b0;
    primary   = 16'sd4000;
    noise     = -16'sd3000;
    delay_sel = 5'd1;
    in_valid  = 1'b1;
    repeat (5) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      if (sb.size() > 0) chk("stall_hold_data", out_data, sb[0].data);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 3; k < 8; k++) send_m(1000 * k, 3000 - 2000 * k, 1, 0, "stall");
    drain("stall");

    // Long delay that wraps the write pointer
    apply_reset();
    for (int k = 0; k < 40; k++) send_m(0, k * 800 - 15000, 31, 1, "wrap");

    // Reset mid-stream: in-flight samples vanish
    primary  = 16'sd77;
    noise    = 16'sd77;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    sb.delete();
    hist.delete();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    send_m(50, 500, 2, 1, "postrst");
    send_m(50, 600, 2, 1, "postrst");
    send_m(50, 700, 2, 1, "postrst");
    send(50, 800, 2, 50 - scale(600), 0, 1, "postrst_hand");
    drain("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anc_noise_subtract.md
ANC_NOISE_SUBTRACT -- requirements
Module: anc_noise_subtract

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed sample width of all data ports.
REQ-002 SHALL have parameter DEPTH, default 32, power of two: noise delay-line length in samples.
REQ-003 SHALL have parameter COEF, default 26123: signed Q15 noise gain, range 0..32767.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1: primary/noise/delay_sel valid this cycle.
REQ-007 SHALL have port in_ready  output  1: block accepts a sample this cycle.
REQ-008 SHALL have port primary  input  DATA_W: signed primary (signal+noise) sample.
REQ-009 SHALL have port noise  input  DATA_W: signed reference-noise sample.
REQ-010 SHALL have port delay_sel  input  log2(DEPTH): noise delay in samples, 0 = current.
REQ-011 SHALL have port out_valid  output  1: out_data/sat_flag valid.
REQ-012 SHALL have port out_ready  input  1: downstream accepts output.
REQ-013 SHALL have port out_data  output  DATA_W: signed cleaned sample.
REQ-014 SHALL have port sat_flag  output  1: out_data was clipped.

Function
REQ-015 SHALL accept a sample on a cycle where in_valid && in_ready; in_ready = !out_valid || out_ready, with the whole pipeline stalling as a unit.
REQ-016 SHALL write each accepted noise sample into a circular buffer at wr_ptr, then increment wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-017 SHALL select delayed noise = sample accepted delay_sel acceptances earlier; delay_sel is sampled with each accepted sample.
REQ-018 SHALL treat a requested slot not yet written since reset as 0, tracked by a fill counter saturating at DEPTH.
REQ-019 SHALL use a 3-stage pipeline: S1 delay-line read, S2 product = delayed*COEF (2*DATA_W signed), S3 diff = primary - scaled (DATA_W+1 bits) with saturation.
REQ-020 SHALL give latency of exactly 3 accepted-clock cycles from acceptance to out_valid, with no bubbles under continuous in_valid and out_ready.
REQ-021 SHALL form scaled = product arithmetically shifted right by 15, per REQ-028.
REQ-022 SHALL clip diff to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and assert sat_flag alongside that output only.
REQ-023 SHALL hold out_data, sat_flag and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL not let primary and delayed noise of one sample separate across stages; simultaneous accept and output in one cycle is legal.

Reset
REQ-025 SHALL on rst: out_valid=0, out_data=0, sat_flag=0, wr_ptr=0, fill count=0, all pipeline valids 0; buffer contents need not be cleared (fill count masks them).
REQ-026 SHALL, on reset mid-operation, discard in-flight samples with no output for them; in_ready=1 the cycle after rst deasserts.
REQ-027 SHALL, while rst is high, ignore in_valid and out_ready.

Configuration
REQ-028 SHALL support macro ANC_ROUND_EN: defined -> add 2^14 to product before shift (round half up); undefined -> plain truncation toward minus infinity.

Structure
REQ-029 SHALL place Q15 constants (COEF default, shift 15, round constant) and the saturate width helper in shared package anc_pkg.
REQ-030 SHALL implement the circular buffer as sub-module anc_delay_line (write port, one read port, registered read).

Verification
REQ-031 SHALL verify, with ANC_ROUND_EN, DATA_W=16: delay_sel=0, noise=1000, primary=1000 -> scaled 797, out_data=203, sat_flag=0, 3 cycles after accept.
REQ-032 SHALL verify delay_sel=3, noise 100,200,300,400, primary 0 -> outputs 0,0,0,-80 (unwritten slots read 0).
REQ-033 SHALL verify delay_sel=0, primary=32767, noise=-32768 -> out_data=32767, sat_flag=1; next sample primary=0, noise=0 -> 0, sat_flag=0.
REQ-034 SHALL verify continuous stream with out_ready low 5 cycles -> in_ready=0, out_data held, no sample lost or duplicated, order preserved.
REQ-035 SHALL verify 40 samples at delay_sel=31 wrap wr_ptr -> output k = -round(noise[k-31]*COEF/32768); rst mid-stream -> out_valid=0 next cycle, first post-reset outputs treat history as 0.
